// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and types for the 7-segment scan decoder
//
// Segment patterns are active-low: bit = 0 means the segment is lit.
// Bit order: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp.
package seg_scan_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Digit patterns with the decimal point off.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

    // Returns {single, index}: single is set only when exactly one select
    // line is low, and index is the digit it selects.
    function automatic logic [2:0] sel_decode(input logic [3:0] sel);
        logic [2:0] r;
        case (sel)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low 7-segment pattern to BCD decoder
//
// Ports:
//   seg     in  [7:0]  active-low segment pattern, dp in bit 0
//   value   out [3:0]  BCD digit, 4'hF when blank or not a digit
//   blank   out        all of a..g off
//   invalid out        neither a digit nor blank
//   dp      out        decimal point lit (independent of the digit decode)
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       invalid,
    output logic       dp
);

    always_comb begin
        value   = 4'hF;
        blank   = 1'b0;
        invalid = 1'b0;
        dp      = ~seg[SEG_DP];
        // The dp bit is excluded so a lit decimal point never changes the digit.
        case (seg[7:1])
            SEG_0[7:1]:     value = 4'd0;
            SEG_1[7:1]:     value = 4'd1;
            SEG_2[7:1]:     value = 4'd2;
            SEG_3[7:1]:     value = 4'd3;
            SEG_4[7:1]:     value = 4'd4;
            SEG_5[7:1]:     value = 4'd5;
            SEG_6[7:1]:     value = 4'd6;
            SEG_7[7:1]:     value = 4'd7;
            SEG_8[7:1]:     value = 4'd8;
            SEG_9[7:1]:     value = 4'd9;
            SEG_BLANK[7:1]: blank = 1'b1;
            default:        invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - deglitching receiver that rebuilds 4-digit snapshots from a scanned display bus
//
// Ports:
//   clk         in        single clock domain
//   rst         in        asynchronous reset, active-low
//   LEDSEL      in  [3:0] digit select, active-low one-hot
//   LEDOUT      in  [7:0] segments, active-low, dp in bit 0
//   digit3..0   out [3:0] decoded BCD per digit, 4'hF when blank or invalid
//   blank       out [3:0] digit i was all segments off
//   invalid     out [3:0] digit i held a non-BCD, non-blank pattern
//   dp          out [3:0] digit i had its decimal point lit
//   frame_done  out       one-cycle pulse; snapshot outputs change on this edge
//   sel_err     out       one-cycle pulse when a stable select has several low bits
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] LEDSEL,
    input  logic [7:0] LEDOUT,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] blank,
    output logic [3:0] invalid,
    output logic [3:0] dp,
    output logic       frame_done,
    output logic       sel_err
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    logic [3:0]       sel_q, sel_d;
    logic [7:0]       out_q, out_d;
    logic [3:0]       cnt_q, cnt_d;
    scan_state_e      state_q, state_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  sh_val_q, sh_val_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0]       sh_inv_q, sh_inv_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       invalid_q, invalid_d;
    logic [3:0]       dp_q, dp_d;
    logic             frame_done_q, frame_done_d;
    logic             sel_err_q, sel_err_d;

    logic [3:0] dec_value;
    logic       dec_blank;
    logic       dec_invalid;
    logic       dec_dp;
    logic [2:0] sel_info;

    seg7_to_bcd u_dec (
        .seg     (out_q),
        .value   (dec_value),
        .blank   (dec_blank),
        .invalid (dec_invalid),
        .dp      (dec_dp)
    );

    assign sel_info = sel_decode(sel_q);

    // Input register and stability counter. cnt_d is the length of the
    // run of identical samples including the one being registered now.
    always_comb begin
        sel_d = LEDSEL;
        out_d = LEDOUT;
        if ({LEDSEL, LEDOUT} == {sel_q, out_q}) begin
            cnt_d = (cnt_q >= STABLE_CNT) ? STABLE_CNT : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd1;
        end
    end

    // State transitions look at cnt_d so that ACCEPT always sees the
    // pattern that completed the stable run in sel_q/out_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   if (cnt_d == STABLE_CNT) state_d = ST_ACCEPT;
            ST_ACCEPT: state_d = (cnt_d == STABLE_CNT) ? ST_HOLD : ST_WAIT;
            ST_HOLD:   if (cnt_d != STABLE_CNT) state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        seen_d       = seen_q;
        sh_val_d     = sh_val_q;
        sh_blank_d   = sh_blank_q;
        sh_inv_d     = sh_inv_q;
        sh_dp_d      = sh_dp_q;
        digit_d      = digit_q;
        blank_d      = blank_q;
        invalid_d    = invalid_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;
        sel_err_d    = 1'b0;

        // Whole-frame publish: every output comes from the same shadow set.
        if (seen_q == 4'hF) begin
            digit_d      = sh_val_q;
            blank_d      = sh_blank_q;
            invalid_d    = sh_inv_q;
            dp_d         = sh_dp_q;
            frame_done_d = 1'b1;
            seen_d       = 4'h0;
        end

        if (state_q == ST_ACCEPT) begin
            if (sel_info[2]) begin
                sh_val_d[sel_info[1:0]]   = dec_value;
                sh_blank_d[sel_info[1:0]] = dec_blank;
                sh_inv_d[sel_info[1:0]]   = dec_invalid;
                sh_dp_d[sel_info[1:0]]    = dec_dp;
                seen_d[sel_info[1:0]]     = 1'b1;
            end else if (sel_q != 4'hF) begin
                // All-high select is inter-digit blanking and is silently skipped.
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q        <= 4'hF;
            out_q        <= 8'hFF;
            cnt_q        <= 4'd0;
            state_q      <= ST_WAIT;
            seen_q       <= 4'h0;
            sh_val_q     <= '0;
            sh_blank_q   <= 4'h0;
            sh_inv_q     <= 4'h0;
            sh_dp_q      <= 4'h0;
            digit_q      <= {4{4'hF}};
            blank_q      <= 4'hF;
            invalid_q    <= 4'h0;
            dp_q         <= 4'h0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            out_q        <= out_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            seen_q       <= seen_d;
            sh_val_q     <= sh_val_d;
            sh_blank_q   <= sh_blank_d;
            sh_inv_q     <= sh_inv_d;
            sh_dp_q      <= sh_dp_d;
            digit_q      <= digit_d;
            blank_q      <= blank_d;
            invalid_q    <= invalid_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign digit3     = digit_q[3];
    assign digit2     = digit_q[2];
    assign digit1     = digit_q[1];
    assign digit0     = digit_q[0];
    assign blank      = blank_q;
    assign invalid    = invalid_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign sel_err    = sel_err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receiving end of the multiplexed 7-segment display bus that the calculator's display mux drives. It samples the scanned LEDSEL/LEDOUT pair, rejects transition glitches, decodes each digit pattern back to BCD, and publishes a coherent 4-digit snapshot once per full scan frame. It is used as an on-board self-check and as the bench's display monitor.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples of {LEDSEL,LEDOUT} needed before a pattern is accepted (legal range 2..15).

Ports:
clk  input  1  system clock; this block uses one clock domain only.
rst  input  1  asynchronous reset, active-low.
LEDSEL  input  4  digit select, active-low one-hot; bit i selects digit i.
LEDOUT  input  8  segments, active-low; [7]=a,[6]=b,[5]=c,[4]=d,[3]=e,[2]=f,[1]=g,[0]=dp.
digit3..digit0  output  4 each  decoded BCD value per digit; 4'hF when blank or invalid.
blank  output  4  bit i set when digit i was all segments off (8'hFF).
invalid  output  4  bit i set when digit i held a non-BCD, non-blank pattern.
dp  output  4  bit i set when digit i's decimal point was lit.
frame_done  output  1  one-cycle pulse; snapshot outputs updated on this same edge.
sel_err  output  1  one-cycle pulse on accepting a stable LEDSEL with more than one low bit.

Behaviour:
- Reset (rst=0, asynchronous): digitN=4'hF, blank=4'hF, invalid=0, dp=0, frame_done=0, sel_err=0, seen mask=0, shadow regs cleared, FSM=WAIT.
- Input stage: LEDSEL/LEDOUT are registered once (s_sel, s_out). All decisions use the registered values.
- Stability counter: if {s_sel,s_out} equals the previous sample, cnt increments, saturating at STABLE_CYCLES. Otherwise cnt=1.
- FSM states:
  - WAIT: when cnt reaches STABLE_CYCLES, go to ACCEPT.
  - ACCEPT: lasts one cycle; acts on the pattern, then goes to HOLD.
  - HOLD: stays while the pattern is unchanged. Any change returns to WAIT.
- Result: at most one acceptance per stable run.
- Acceptance actions:
  - s_sel one-hot-low at index i: write the decoded value into shadow slot i and set seen[i]. A repeat of i within the frame overwrites the slot and is not counted twice.
  - s_sel=4'hF (inter-digit blanking): ignored, no error.
  - Multiple low bits: sel_err pulses for one cycle; no capture; seen unchanged.
- Frame completion: on the cycle after seen becomes 4'hF, all shadow slots are copied to the outputs in a single edge, frame_done pulses, and seen clears. Outputs never mix two frames.
- Decode rules:
  - Patterns 0-9 (package constants) → value, blank=0, invalid=0.
  - 8'hFF ignoring dp → value F, blank=1.
  - Any other pattern → value F, invalid=1.
  - dp = ~LEDOUT[0], independent of the digit decode.
- Latency: from the first port edge of a new pattern, acceptance occurs STABLE_CYCLES+1 edges later. frame_done follows one edge after the fourth distinct acceptance.
- Boundaries:
  - A pattern shorter than STABLE_CYCLES is never captured.
  - cnt saturates and does not wrap.
  - Reset asserted mid-frame discards partial shadow contents.
  - No frame_done is produced until all four digits have been seen after reset.

Decomposition:
- Package seg_scan_pkg holds:
  - segment bit-position constants;
  - the SEG_0..SEG_9 and SEG_BLANK pattern constants;
  - the FSM state encoding (WAIT, ACCEPT, HOLD).
- One natural sub-module, seg7_to_bcd: combinational; input 8-bit pattern; outputs value[3:0], blank, invalid, dp. It is instantiated once on s_out.

Test Plan:
- Reset then scan digits 0..3 showing 8'h03 ('0'), 8'h9F ('1'), 8'h0D ('3'), 8'h1F ('7'), each held 20 cycles with STABLE_CYCLES=4 → one frame_done; digit0=0, digit1=1, digit2=3, digit3=7; blank=0, invalid=0, dp=0.
- Glitch: LEDSEL=4'b1110 with LEDOUT=8'h0D for 3 cycles, then LEDOUT=8'h03 held → slot 0 captures 0, never 3.
- Blank and invalid: digit 2 = 8'hFF, digit 3 = 8'h55, digit 0 = 8'h0C (dp lit), digit 1 = 8'h9F → blank=4'b0100, invalid=4'b1000, dp=4'b0001, digit2=digit3=4'hF.
- Select error: LEDSEL=4'b1100 held 10 cycles → exactly one sel_err pulse, no capture; LEDSEL=4'hF held → no pulse.
- Repeat capture: scan digits 0,1,0(new value),2,3 → one frame_done, and digit0 holds the second value.
- Async reset mid-frame after digits 0 and 1 captured → outputs return to reset values at once; after release, a full 4-digit scan is required before frame_done.
